// File: rtl/csa_pkg.sv
// csa_pkg: types and constants shared by the carry-save accumulation blocks.
//   csa_seq_state_t  : sequencer FSM state encoding
//   CSA_OPS_PER_BEAT : operands delivered per op_valid/op_ready beat
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } csa_seq_state_t;

  localparam int CSA_OPS_PER_BEAT = 2;

endpackage

// File: rtl/csa_accum_seq_tree_4_2.sv
// tree_4_2: WIDTH-bit 4:2 carry-save compressor built from an array of
// per-bit cells. Each cell is two chained full adders; the first adder's
// carry ripples only one bit sideways (cin/cout), so depth is constant.
//   in0..in3 : four WIDTH-bit addends
//   sum      : redundant sum, weight 2^i
//   carry    : redundant carry, bit i has weight 2^(i+1)
//   cout     : lateral carry out of the MSB cell (weight 2^WIDTH)
// in0+in1+in2+in3 == sum + 2*carry (mod 2^WIDTH).

module csa_4_2_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;
  assign s1    = a ^ b ^ c;
  assign cout  = (a & b) | (a & c) | (b & c);
  assign sum   = s1 ^ d ^ cin;
  assign carry = (s1 & d) | (s1 & cin) | (d & cin);
endmodule

module tree_4_2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout
);
  // lat[i] is the lateral carry entering bit i; lat[i+1] leaves it.
  logic [WIDTH:0] lat;
  assign lat[0] = 1'b0;
  assign cout   = lat[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    csa_4_2_cell u_cell (
      .a     (in0[i]),
      .b     (in1[i]),
      .c     (in2[i]),
      .d     (in3[i]),
      .cin   (lat[i]),
      .sum   (sum[i]),
      .carry (carry[i]),
      .cout  (lat[i+1])
    );
  end
endmodule

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: multi-operand accumulation sequencer.
// Takes n_ops operands two per beat, folds each beat into a redundant
// (s_q, c_q) pair through a 4:2 compressor, then does one carry-propagate
// add and offers the sum on a valid/ready output.
//   clk, reset  : clock, synchronous active-high reset
//   start,n_ops : begin a transaction of n_ops operands (sampled in IDLE)
//   busy        : any state other than IDLE
//   op_valid/op_ready/op_a/op_b : operand beat handshake (ready in ACCUM)
//   res_valid/res_ready/result  : result handshake (valid in DONE)
// All outputs come straight from registers or the state register.

module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_ops,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BEAT  = CNT_W'(CSA_OPS_PER_BEAT);

  csa_seq_state_t   state;
  logic [WIDTH-1:0] s_q, c_q, res_q;
  logic [CNT_W-1:0] rem_q;

  logic [WIDTH-1:0] c_sh;      // carry realigned to its true weight
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] t_sum, t_carry;
  logic             t_cout;
  logic [CNT_W-1:0] step;
  logic             last_beat;

  // Carry bit i carries weight 2^(i+1); the MSB carry falls off modulo 2^WIDTH.
  assign c_sh = {c_q[WIDTH-2:0], 1'b0};

  // Odd operand count: the final beat holds a single real operand.
  assign b_eff     = (rem_q == CNT_ONE) ? '0 : op_b;
  assign step      = (rem_q < CNT_BEAT) ? rem_q : CNT_BEAT;
  assign last_beat = (rem_q <= CNT_BEAT);

  tree_4_2 #(.WIDTH(WIDTH)) u_tree (
    .in0   (s_q),
    .in1   (c_sh),
    .in2   (op_a),
    .in3   (b_eff),
    .sum   (t_sum),
    .carry (t_carry),
    .cout  (t_cout)
  );

  // Bits above 2^WIDTH are dropped by design (modulo arithmetic).
  logic unused_hi;
  assign unused_hi = c_q[WIDTH-1] ^ t_cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_q   <= '0;
      c_q   <= '0;
      rem_q <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (n_ops != '0) begin
              s_q   <= '0;
              c_q   <= '0;
              rem_q <= n_ops;
              state <= ACCUM;
            end else begin
              // Empty transaction: result is trivially zero.
              res_q <= '0;
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (op_valid) begin
            s_q   <= t_sum;
            c_q   <= t_carry;
            rem_q <= rem_q - step;
            if (last_beat) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          res_q <= s_q + c_sh;
          state <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq (WIDTH=32, CNT_W=8). Inputs are driven
// and outputs sampled on the falling edge; expected values are hand-computed.
module tb_csa_accum_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  n_ops;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;

  int n_chk  = 0;
  int n_pass = 0;
  int beats  = 0;
  int rdy_cyc = 0;

  always #5 clk = ~clk;

  csa_accum_seq #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_ops     (n_ops),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  // Accepted beats and op_ready-high cycles, seen at the active edge.
  always @(posedge clk) begin
    if (op_valid && op_ready) beats <= beats + 1;
    if (op_ready) rdy_cyc <= rdy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue start for one edge; returns at the negedge of cycle 1 after it.
  task automatic go(input logic [7:0] n);
    start = 1'b1;
    n_ops = n;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for res_valid; cyc counts cycles since the start edge.
  task automatic wait_res(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!res_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!res_valid) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_take", {30'd0, busy, res_valid}, 32'd0);
  endtask

  int cyc, b0, r0;

  initial begin
    reset = 1'b1; start = 1'b0; n_ops = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_result", result, 32'd0);

    // n_ops=1: op_b must be ignored; result after 3 cycles.
    b0 = beats;
    op_valid = 1'b1; op_a = 32'd5; op_b = 32'hFFFF;
    go(8'd1);
    chk("t1_op_ready", {31'd0, op_ready}, 32'd1);
    wait_res(1, cyc);
    chk("t1_latency", cyc, 32'd3);
    chk("t1_result", result, 32'd5);
    chk("t1_beats", beats - b0, 32'd1);
    op_valid = 1'b0;
    take_res();

    // n_ops=4 with a 3-cycle gap between beats.
    b0 = beats;
    go(8'd4);
    op_valid = 1'b1; op_a = 32'd1; op_b = 32'd2;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_gap_ready", {31'd0, op_ready}, 32'd1);
      tick();
    end
    op_valid = 1'b1; op_a = 32'd3; op_b = 32'd4;
    tick();
    op_valid = 1'b0;
    wait_res(0, cyc);
    chk("t2_result", result, 32'd10);
    chk("t2_beats", beats - b0, 32'd2);
    take_res();

    // n_ops=7, all ones: -7 mod 2^32; 4th beat's op_b dropped.
    b0 = beats;
    op_valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    go(8'd7);
    wait_res(1, cyc);
    op_valid = 1'b0;
    chk("t3_latency", cyc, 32'd6);
    chk("t3_result", result, 32'hFFFF_FFF9);
    chk("t3_beats", beats - b0, 32'd4);
    take_res();

    // n_ops=0: DONE in one cycle, zero result, no op_ready.
    r0 = rdy_cyc;
    go(8'd0);
    wait_res(1, cyc);
    chk("t4_latency", cyc, 32'd1);
    chk("t4_result", result, 32'd0);
    chk("t4_no_ready", rdy_cyc - r0, 32'd0);
    take_res();

    // Hold DONE with res_ready low while start pulses.
    op_valid = 1'b1; op_a = 32'd3; op_b = 32'd4;
    go(8'd2);
    wait_res(1, cyc);
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = i[0] ? 1'b0 : 1'b1;
      n_ops = 8'd1;
      tick();
      chk("t5_hold_result", result, 32'd7);
      chk("t5_hold_busy", {30'd0, busy, res_valid}, 32'd3);
    end
    start = 1'b0;
    take_res();
    op_valid = 1'b1; op_a = 32'd9; op_b = 32'd1;
    go(8'd1);
    wait_res(1, cyc);
    op_valid = 1'b0;
    chk("t5_next_result", result, 32'd9);
    take_res();

    // Reset mid-ACCUM, then a clean transaction.
    go(8'd8);
    op_valid = 1'b1; op_a = 32'd1; op_b = 32'd1;
    tick(); tick();
    op_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_rst_result", result, 32'd0);
    op_valid = 1'b1; op_a = 32'd7; op_b = 32'd9;
    go(8'd2);
    wait_res(1, cyc);
    op_valid = 1'b0;
    chk("t6_latency", cyc, 32'd3);
    chk("t6_result", result, 32'd16);
    take_res();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
